// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and selectable registered or FWFT read port.
module sync_fifo_flags #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2,
  parameter int FWFT   = 0,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_write,
  input  logic              i_read,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clr_err,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_almost_empty,
  output logic              o_almost_full,
  output logic              o_overflow,
  output logic              o_underflow,
  output logic [CNT_W-1:0]  o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              rd_ok;
  logic              wr_ok;
  logic              empty;
  logic              full;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A push into a full FIFO is accepted when a pop frees a slot in the same cycle.
  assign rd_ok = i_read && !empty;
  assign wr_ok = i_write && (!full || rd_ok);

  assign o_empty        = empty;
  assign o_full         = full;
  assign o_almost_full  = (count >= AF_CNT);
  assign o_almost_empty = (count <= AE_CNT);
  assign o_count        = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (wr_ok && !rd_ok) begin
      count <= count + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count <= count - 1'b1;
    end
  end

  // Explicit wrap keeps non-power-of-two depths correct.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wr_ptr] <= i_data;
  end

  // A new error event in the same cycle as i_clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_write && !wr_ok)  o_overflow <= 1'b1;
      else if (i_clr_err)     o_overflow <= 1'b0;
      if (i_read && !rd_ok)   o_underflow <= 1'b1;
      else if (i_clr_err)     o_underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign o_data  = empty ? '0 : mem[rd_ptr];
    assign o_valid = !empty;
  end else begin : g_reg
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_ok;
        if (rd_ok) data_q <= mem[rd_ptr];
      end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a 16-deep registered-read FIFO and a 5-deep FWFT
// FIFO driven in lockstep and compared against a queue-based reference model.
module tb_sync_fifo_flags;

  typedef logic [7:0] byte_t;

  typedef struct {
    bit    rst, wr, rd, clr;
    byte_t din;
    int    cnt;
    bit    valid;
    byte_t data;
    bit    udf;
    bit    ovf;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst, i_write, i_read, i_clr_err;
  byte_t i_data;

  byte_t      a_data, b_data;
  logic       a_valid, a_empty, a_full, a_ae, a_af, a_ovf, a_udf;
  logic       b_valid, b_empty, b_full, b_ae, b_af, b_ovf, b_udf;
  logic [4:0] a_cnt;
  logic [3:0] b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_W(8), .DEPTH(16), .AF_LVL(14), .AE_LVL(2), .FWFT(0)) dut_a (
    .clk(clk), .rst(rst), .i_write(i_write), .i_read(i_read), .i_data(i_data),
    .i_clr_err(i_clr_err), .o_data(a_data), .o_valid(a_valid), .o_empty(a_empty),
    .o_full(a_full), .o_almost_empty(a_ae), .o_almost_full(a_af),
    .o_overflow(a_ovf), .o_underflow(a_udf), .o_count(a_cnt)
  );

  sync_fifo_flags #(.DATA_W(8), .DEPTH(5), .AF_LVL(4), .AE_LVL(1), .FWFT(1)) dut_b (
    .clk(clk), .rst(rst), .i_write(i_write), .i_read(i_read), .i_data(i_data),
    .i_clr_err(i_clr_err), .o_data(b_data), .o_valid(b_valid), .o_empty(b_empty),
    .o_full(b_full), .o_almost_empty(b_ae), .o_almost_full(b_af),
    .o_overflow(b_ovf), .o_underflow(b_udf), .o_count(b_cnt)
  );

  // Reference model: contents as a queue, flags computed from its size.
  int    dep[2] = '{16, 5};
  int    afl[2] = '{14, 4};
  int    ael[2] = '{2, 1};
  int    fw[2]  = '{0, 1};
  byte_t qa[$];
  byte_t qb[$];
  bit    movf[2], mudf[2], mvalid[2];
  byte_t mdata[2];

  function automatic int qsize(int k);
    return (k == 0) ? qa.size() : qb.size();
  endfunction

  function automatic byte_t qhead(int k);
    return (k == 0) ? qa[0] : qb[0];
  endfunction

  function automatic byte_t qpop(int k);
    if (k == 0) return qa.pop_front();
    return qb.pop_front();
  endfunction

  function automatic void qpush(int k, byte_t d);
    if (k == 0) qa.push_back(d);
    else qb.push_back(d);
  endfunction

  function automatic void chk(string nm, int k, int unsigned act, int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endfunction

  function automatic void mupdate(int k, bit r, bit w, bit rd, bit c, byte_t d);
    int    n;
    bit    rok, wok;
    byte_t x;
    n   = qsize(k);
    rok = rd && (n > 0);
    wok = w && ((n < dep[k]) || rok);
    if (r) begin
      if (k == 0) qa.delete(); else qb.delete();
      movf[k] = 0; mudf[k] = 0; mvalid[k] = 0; mdata[k] = 8'h00;
    end else begin
      mvalid[k] = 0;
      if (rok) begin
        x = qpop(k);
        if (fw[k] == 0) begin
          mdata[k]  = x;
          mvalid[k] = 1;
        end
      end
      if (wok) qpush(k, d);
      if (w && !wok) movf[k] = 1; else if (c) movf[k] = 0;
      if (rd && !rok) mudf[k] = 1; else if (c) mudf[k] = 0;
    end
  endfunction

  function automatic void check_model();
    for (int k = 0; k < 2; k++) begin
      int    n;
      bit    ev;
      byte_t ed;
      n  = qsize(k);
      ev = (fw[k] != 0) ? (n > 0) : mvalid[k];
      ed = (fw[k] != 0) ? ((n > 0) ? qhead(k) : 8'h00) : mdata[k];
      chk("count", k, (k == 0) ? a_cnt : b_cnt, n);
      chk("empty", k, (k == 0) ? a_empty : b_empty, n == 0);
      chk("full", k, (k == 0) ? a_full : b_full, n == dep[k]);
      chk("almost_full", k, (k == 0) ? a_af : b_af, n >= afl[k]);
      chk("almost_empty", k, (k == 0) ? a_ae : b_ae, n <= ael[k]);
      chk("overflow", k, (k == 0) ? a_ovf : b_ovf, movf[k]);
      chk("underflow", k, (k == 0) ? a_udf : b_udf, mudf[k]);
      chk("valid", k, (k == 0) ? a_valid : b_valid, ev);
      if (ev || fw[k] != 0 || mdata[k] == 8'h00)
        chk("data", k, (k == 0) ? a_data : b_data, ed);
    end
  endfunction

  task automatic step(bit r, bit w, bit rd, bit c, byte_t d);
    rst = r; i_write = w; i_read = rd; i_clr_err = c; i_data = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) mupdate(k, r, w, rd, c, d);
    #1;
    check_model();
  endtask

  vec_t tbl[10];

  initial begin
    // Hand-derived expectations for the 16-deep registered-read instance.
    tbl[0] = '{1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0};
    tbl[1] = '{0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 1, 0};
    tbl[2] = '{0, 0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0};
    tbl[3] = '{0, 1, 1, 0, 8'h77, 1, 0, 8'h00, 1, 0};
    tbl[4] = '{0, 1, 0, 0, 8'h11, 2, 0, 8'h00, 1, 0};
    tbl[5] = '{0, 0, 1, 0, 8'h00, 1, 1, 8'h77, 1, 0};
    tbl[6] = '{0, 1, 1, 0, 8'h22, 1, 1, 8'h11, 1, 0};
    tbl[7] = '{0, 0, 0, 0, 8'h00, 1, 0, 8'h11, 1, 0};
    tbl[8] = '{0, 0, 1, 1, 8'h00, 0, 1, 8'h22, 0, 0};
    tbl[9] = '{0, 0, 1, 1, 8'h00, 0, 0, 8'h22, 1, 0};

    rst = 1'b1; i_write = 1'b0; i_read = 1'b0; i_clr_err = 1'b0; i_data = 8'h00;
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
      chk("tbl_count", i, a_cnt, tbl[i].cnt);
      chk("tbl_valid", i, a_valid, tbl[i].valid);
      chk("tbl_data", i, a_data, tbl[i].data);
      chk("tbl_underflow", i, a_udf, tbl[i].udf);
      chk("tbl_overflow", i, a_ovf, tbl[i].ovf);
    end

    // Fill, overflow, full push+pop, drain.
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, byte_t'(i));
    chk("fill_count", 0, a_cnt, 16);
    chk("fill_full", 0, a_full, 1);
    step(0, 1, 0, 0, 8'hAA);
    chk("fill_overflow", 0, a_ovf, 1);
    step(0, 0, 0, 1, 8'h00);
    step(0, 1, 1, 0, 8'h55);
    chk("full_pp_count", 0, a_cnt, 16);
    chk("full_pp_overflow", 0, a_ovf, 0);
    chk("full_pp_data", 0, a_data, 8'h00);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 8'h00);
    chk("drain_last", 0, a_data, 8'h55);
    chk("drain_empty", 0, a_empty, 1);

    // Empty push+pop: FWFT instance shows the word next cycle.
    step(0, 1, 1, 0, 8'h77);
    chk("epp_fwft_data", 1, b_data, 8'h77);
    chk("epp_fwft_valid", 1, b_valid, 1);
    chk("epp_underflow", 0, a_udf, 1);

    // Threshold edges, then reset mid-stream with a write pending.
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 14; i++) step(0, 1, 0, 0, byte_t'(8'h30 + i));
    chk("af_at_14", 0, a_af, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 8'h00);
    chk("ae_at_2", 0, a_ae, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, byte_t'(8'h60 + i));
    chk("pre_rst_count", 0, a_cnt, 7);
    step(1, 1, 0, 0, 8'hEE);
    chk("rst_count", 0, a_cnt, 0);
    chk("rst_data", 0, a_data, 8'h00);

    // Pointer wrap on the 5-deep instance, then clear the sticky flag.
    step(0, 0, 1, 0, 8'h00);
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 4; j++) step(0, 1, 0, 0, byte_t'(16 * r + j + 1));
      for (int j = 0; j < 4; j++) step(0, 0, 1, 0, 8'h00);
    end
    step(0, 0, 0, 1, 8'h00);
    chk("clr_underflow", 1, b_udf, 0);

    // Randomized phases alternating fill-biased and drain-biased traffic.
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = (((i / 200) % 2) != 0) ? 75 : 30;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 99) < wp,
           $urandom_range(0, 99) < (100 - wp), $urandom_range(0, 19) == 0,
           byte_t'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
